// File: rtl/mem_req_ctrl.sv
// Queues line read/write requests and plays them one at a time onto the mainmemory strobe port.
// Each request gets exactly one response pulse. Out-of-range addresses and timeouts answer with an error.
module mem_req_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 27,
   parameter int ENTRIES    = 256,
   parameter int TIMEOUT    = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_be,
   input  logic [255:0]      req_wd,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic              rsp_err,
   output logic [255:0]      rsp_rdata,
   output logic [ADDR_W-1:0] mm_a,
   output logic [31:0]       mm_be,
   output logic [255:0]      mm_wd,
   output logic              mm_read,
   output logic              mm_write,
   input  logic [255:0]      mm_rd,
   input  logic              mm_valid,
   input  logic              mm_ready
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]     FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] ENT_LIM  = ADDR_W'(ENTRIES);

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       be;
      logic [255:0]      wd;
   } req_t;

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, RESP} state_t;

   req_t          fifo_q [FIFO_DEPTH];
   req_t          head;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ready_q;
   logic          push, pop;

   state_t            state_q;
   logic              op_q;
   logic [TW-1:0]     tmo_q;
   logic [ADDR_W-1:0] mm_a_q;
   logic [31:0]       mm_be_q;
   logic [255:0]      mm_wd_q;
   logic              mm_read_q, mm_write_q;
   logic              rsp_valid_q, rsp_write_q, rsp_err_q;
   logic [255:0]      rsp_rdata_q;

   assign head = fifo_q[rd_ptr_q];
   assign push = req_valid & ready_q;
   assign pop  = (state_q == IDLE) && (cnt_q != '0);

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + 1'b1;
      else if (!push && pop)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_q[wr_ptr_q] <= '{write: req_write, addr: req_addr, be: req_be, wd: req_wd};
   end

   // ready is the registered not-full flag, held low while in reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ready_q  <= 1'b0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q   <= cnt_d;
         ready_q <= (cnt_d != FULL_CNT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= 1'b0;
         tmo_q       <= '0;
         mm_a_q      <= '0;
         mm_be_q     <= '0;
         mm_wd_q     <= '0;
         mm_read_q   <= 1'b0;
         mm_write_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         mm_read_q   <= 1'b0;
         mm_write_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         case (state_q)
            IDLE: begin
               if (cnt_q != '0) begin
                  mm_a_q  <= head.addr;
                  mm_be_q <= head.be;
                  mm_wd_q <= head.wd;
                  op_q    <= head.write;
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               if (mm_a_q >= ENT_LIM) begin
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= op_q;
                  rsp_err_q   <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  mm_read_q  <= !op_q;
                  mm_write_q <= op_q;
                  state_q    <= STROBE;
               end
            end
            STROBE: begin
               tmo_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               tmo_q <= tmo_q + 1'b1;
               if (!op_q && mm_valid) begin
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= mm_rd;
                  state_q     <= RESP;
               end else if (op_q && mm_ready) begin
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= 1'b1;
                  state_q     <= RESP;
               end else if (tmo_q == TMO_LAST) begin
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= op_q;
                  rsp_err_q   <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mm_a      = mm_a_q;
   assign mm_be     = mm_be_q;
   assign mm_wd     = mm_wd_q;
   assign mm_read   = mm_read_q;
   assign mm_write  = mm_write_q;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: two-cycle mainmemory stub, in-order response scoreboard.
module tb_mem_req_ctrl;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid, req_ready, req_write;
   logic [26:0]  req_addr;
   logic [31:0]  req_be;
   logic [255:0] req_wd;
   logic         rsp_valid, rsp_write, rsp_err;
   logic [255:0] rsp_rdata;
   logic [26:0]  mm_a;
   logic [31:0]  mm_be;
   logic [255:0] mm_wd;
   logic         mm_read, mm_write;
   logic [255:0] mm_rd;
   logic         mm_valid, mm_ready;

   mem_req_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_be(req_be), .req_wd(req_wd),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .mm_a(mm_a), .mm_be(mm_be), .mm_wd(mm_wd), .mm_read(mm_read), .mm_write(mm_write),
      .mm_rd(mm_rd), .mm_valid(mm_valid), .mm_ready(mm_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         w;
      logic         err;
      logic [255:0] d;
   } exp_t;

   int total = 0;
   int bad = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   int rsp_cnt = 0;
   exp_t exp_q[$];
   exp_t e;
   logic [255:0] mem   [256];
   logic [255:0] model [256];
   logic         mute;
   logic         s_rd, s_wr, p_rd, p_wr;
   logic [7:0]   s_a;
   logic [31:0]  s_be;
   logic [255:0] s_wd, p_dat;
   logic [26:0]  prev_a;
   logic         prev_rd, prev_wr;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] pat(input int i);
      return {8{32'h5A000000 | 32'(i)}};
   endfunction

   // memory stub: answers two cycles after it sees a strobe, unless muted
   always @(posedge clk) begin
      s_rd = mm_read; s_wr = mm_write; s_a = mm_a[7:0]; s_be = mm_be; s_wd = mm_wd;
      #1;
      mm_valid = p_rd;
      mm_ready = p_wr;
      mm_rd    = p_rd ? p_dat : '0;
      p_rd  = s_rd && !mute;
      p_wr  = s_wr && !mute;
      p_dat = mem[s_a];
      if (s_wr && !mute)
         for (int i = 0; i < 32; i++)
            if (s_be[i]) mem[s_a][8*i +: 8] = s_wd[8*i +: 8];
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (mm_read) rd_cnt++;
         if (mm_write) wr_cnt++;
         if (mm_read || mm_write) begin
            chk("addr_setup", 256'(mm_a), 256'(prev_a));
            chk("strobe_width", 256'((mm_read && prev_rd) || (mm_write && prev_wr)), 256'(0));
         end
         if (rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() == 0) chk("unexpected_rsp", 256'(1), 256'(0));
            else begin
               e = exp_q.pop_front();
               chk("rsp_write", 256'(rsp_write), 256'(e.w));
               chk("rsp_err", 256'(rsp_err), 256'(e.err));
               chk("rsp_rdata", rsp_rdata, e.d);
            end
         end else
            chk("rdata_idle", rsp_rdata, '0);
      end
      prev_a  = mm_a;
      prev_rd = mm_read;
      prev_wr = mm_write;
   end

   task automatic push(input logic w, input logic [26:0] a, input logic [255:0] d,
                       input logic [31:0] be, input logic err);
      int n;
      exp_t x;
      req_valid = 1'b1; req_write = w; req_addr = a; req_be = be; req_wd = d;
      n = 0;
      while (!req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("push_ready", 256'(req_ready), 256'(1));
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      x.w   = w;
      x.err = err;
      x.d   = (w || err) ? '0 : model[a[7:0]];
      if (w && !err)
         for (int i = 0; i < 32; i++)
            if (be[i]) model[a[7:0]][8*i +: 8] = d[8*i +: 8];
      exp_q.push_back(x);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("drain", 256'(exp_q.size()), 256'(0));
   endtask

   task automatic rsp_latency(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 100);
   endtask

   initial begin
      int n, r0, w0, c0;
      for (int i = 0; i < 256; i++) begin
         mem[i]   = pat(i);
         model[i] = pat(i);
      end
      mute = 1'b0; p_rd = 1'b0; p_wr = 1'b0; p_dat = '0;
      mm_valid = 1'b0; mm_ready = 1'b0; mm_rd = '0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_be = '0; req_wd = '0;
      rst_n = 1'b0;

      // reset state
      #3;
      chk("rst_req_ready", 256'(req_ready), 256'(0));
      chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
      chk("rst_strobes", 256'({mm_read, mm_write}), 256'(0));
      chk("rst_mm_a", 256'(mm_a), 256'(0));
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); @(negedge clk);
      chk("post_rst_ready", 256'(req_ready), 256'(1));

      // 1: write then read of one line, nominal latency
      r0 = rd_cnt; w0 = wr_cnt;
      push(1'b1, 27'h10, {32{8'hAA}}, 32'hFFFF_FFFF, 1'b0);
      rsp_latency(n);
      chk("wr_latency", 256'(n), 256'(6));
      push(1'b0, 27'h10, '0, '0, 1'b0);
      rsp_latency(n);
      chk("rd_latency", 256'(n), 256'(6));
      drain();
      chk("one_rd_pulse", 256'(rd_cnt - r0), 256'(1));
      chk("one_wr_pulse", 256'(wr_cnt - w0), 256'(1));

      // 2: fill the FIFO behind a request in flight
      push(1'b1, 27'h09, {8{32'h1234_5678}}, 32'hFFFF_FFFF, 1'b0);
      for (int i = 0; i < 4; i++) push(1'b0, 27'(i), '0, '0, 1'b0);
      chk("full_ready_low", 256'(req_ready), 256'(0));
      push(1'b0, 27'd4, '0, '0, 1'b0);
      drain();

      // 3: out-of-range address never strobes
      r0 = rd_cnt;
      push(1'b0, 27'h100, '0, '0, 1'b1);
      drain();
      chk("oor_no_strobe", 256'(rd_cnt - r0), 256'(0));

      // 4: silent memory times out, next request recovers
      mute = 1'b1;
      push(1'b0, 27'd3, '0, '0, 1'b1);
      push(1'b0, 27'd4, '0, '0, 1'b0);
      n = 0;
      while (!mm_read && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_strobe_seen", 256'(mm_read), 256'(1));
      rsp_latency(n);
      chk("tmo_latency", 256'(n), 256'(16));
      mute = 1'b0;
      drain();

      // 5: reset during WAIT with two requests queued
      mute = 1'b1;
      push(1'b0, 27'd5, '0, '0, 1'b1);
      push(1'b0, 27'd6, '0, '0, 1'b1);
      push(1'b0, 27'd7, '0, '0, 1'b1);
      n = 0;
      while (!mm_read && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_mm_a", 256'(mm_a), 256'(0));
      chk("arst_mm_be", 256'(mm_be), 256'(0));
      chk("arst_mm_wd", mm_wd, '0);
      chk("arst_strobes", 256'({mm_read, mm_write}), 256'(0));
      chk("arst_rsp", 256'({rsp_valid, rsp_write, rsp_err}), 256'(0));
      chk("arst_ready", 256'(req_ready), 256'(0));
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      mute = 1'b0;
      r0 = rd_cnt; w0 = wr_cnt; c0 = rsp_cnt;
      repeat (3) @(negedge clk);
      chk("rel_ready", 256'(req_ready), 256'(1));
      repeat (30) @(negedge clk);
      chk("rel_no_rsp", 256'(rsp_cnt - c0), 256'(0));
      chk("rel_no_strobe", 256'((rd_cnt - r0) + (wr_cnt - w0)), 256'(0));

      // 6: push coinciding with pop at count 3, then 16 requests through wrap
      push(1'b0, 27'h30, '0, '0, 1'b0);
      push(1'b0, 27'h31, '0, '0, 1'b0);
      push(1'b0, 27'h32, '0, '0, 1'b0);
      push(1'b0, 27'h33, '0, '0, 1'b0);
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      push(1'b0, 27'h34, '0, '0, 1'b0);
      chk("pushpop_ready", 256'(req_ready), 256'(1));
      push(1'b0, 27'h35, '0, '0, 1'b0);
      chk("pushpop_full", 256'(req_ready), 256'(0));
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0)
            push(1'b1, 27'(8'h40 + i / 2), {8{32'hD000_0000 + 32'(i)}},
                 (i % 4 == 2) ? 32'h0F0F_0F0F : 32'hFFFF_FFFF, 1'b0);
         else
            push(1'b0, 27'(8'h40 + (i - 1) / 2), '0, '0, 1'b0);
      end
      drain();
      chk("final_q_empty", 256'(exp_q.size()), 256'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
